// File: rtl/pll_lock_reset_pkg.sv
// Shared types and constants for the PLL lock reset sequencer.
// State encoding is fixed so that debug probes can decode it directly.
package pll_lock_reset_pkg;

    typedef enum logic [2:0] {
        RST        = 3'd0,
        WAIT_LOCK  = 3'd1,
        SETTLE     = 3'd2,
        REL_PERIPH = 3'd3,
        RUN        = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_ff.sv
// Parameterised-depth single-bit synchronizer with async active-low reset.
// Reusable for any single CDC bit; output is the last flop of the chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Staged peripheral/core reset release driven by a synchronized PLL lock.
// Define PLL_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_lock_reset_seq
    import pll_lock_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CORE_DELAY    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  lock_i,
    output logic                  rstn_periph_o,
    output logic                  rstn_core_o,
    output logic                  ready_o,
    output logic                  lock_lost_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CORE_DELAY) ?
                             SETTLE_CYCLES : CORE_DELAY;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CORE_LAST   = CW'(CORE_DELAY - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (CORE_DELAY < 1) begin : g_bad_core
        $error("CORE_DELAY must be >= 1");
    end

    logic          lock_s;
    logic          loss_evt;
    state_t        state;
    logic [CW-1:0] cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (lock_i),
        .q    (lock_s)
    );

    // Loss only counts once the lock has qualified through SETTLE.
    assign loss_evt = ((state == REL_PERIPH) || (state == RUN)) && !lock_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= RST;
            cnt           <= '0;
            rstn_periph_o <= 1'b0;
            rstn_core_o   <= 1'b0;
            ready_o       <= 1'b0;
            lock_lost_o   <= 1'b0;
        end else begin
            lock_lost_o <= 1'b0;
            unique case (state)
                RST: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                end
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (lock_s) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state         <= REL_PERIPH;
                        cnt           <= '0;
                        rstn_periph_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REL_PERIPH, RUN: begin
                    if (loss_evt) begin
                        state         <= WAIT_LOCK;
                        cnt           <= '0;
                        rstn_periph_o <= 1'b0;
                        rstn_core_o   <= 1'b0;
                        ready_o       <= 1'b0;
                        lock_lost_o   <= 1'b1;
                    end else if (state == REL_PERIPH) begin
                        if (cnt == CORE_LAST) begin
                            state       <= RUN;
                            cnt         <= '0;
                            rstn_core_o <= 1'b1;
                            ready_o     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state         <= RST;
                    cnt           <= '0;
                    rstn_periph_o <= 1'b0;
                    rstn_core_o   <= 1'b0;
                    ready_o       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign loss_cnt_o = loss_cnt;
`else
    assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq: default-parameter instance for
// sequencing timing, short-parameter instance for the loss counter.
module tb_pll_lock_reset_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       lock_i;
    logic       lock2;
    logic       periph, core, ready, lost;
    logic [7:0] loss_cnt;
    logic       periph2, core2, ready2, lost2;
    logic [7:0] loss_cnt2;

    int checks = 0;
    int failures = 0;

`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    pll_lock_reset_seq dut (
        .clk           (clk),
        .rstn          (rstn),
        .lock_i        (lock_i),
        .rstn_periph_o (periph),
        .rstn_core_o   (core),
        .ready_o       (ready),
        .lock_lost_o   (lost),
        .loss_cnt_o    (loss_cnt)
    );

    pll_lock_reset_seq #(
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (4),
        .CORE_DELAY    (2)
    ) dut_small (
        .clk           (clk),
        .rstn          (rstn),
        .lock_i        (lock2),
        .rstn_periph_o (periph2),
        .rstn_core_o   (core2),
        .ready_o       (ready2),
        .lock_lost_o   (lost2),
        .loss_cnt_o    (loss_cnt2)
    );

    task automatic restart();
        rstn   = 1'b0;
        lock_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        lock_i = 1'b1;
        lock2  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({periph, core, ready, lost} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {periph, core, ready, lost});
        end
        checks++;
        if (loss_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_loss_cnt got=%h exp=00", loss_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_power_up();
        int fp = -1, fc = -1, fr = -1, pulses = 0, viol = 0;
        for (int e = 0; e < 1100; e++) begin
            @(posedge clk);
            #1;
            if (periph === 1'b1 && fp < 0) fp = e;
            if (core === 1'b1 && fc < 0) fc = e;
            if (ready === 1'b1 && fr < 0) fr = e;
            if (lost !== 1'b0) pulses++;
            if (core === 1'b1 && periph !== 1'b1) viol++;
        end
        checks++;
        if (fp != 1026) begin
            failures++;
            $display("FAIL pu_periph_edge got=%0d exp=1026", fp);
        end
        checks++;
        if (fc != 1042) begin
            failures++;
            $display("FAIL pu_core_edge got=%0d exp=1042", fc);
        end
        checks++;
        if (fr != 1042) begin
            failures++;
            $display("FAIL pu_ready_edge got=%0d exp=1042", fr);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL pu_lock_lost got=%0d exp=0", pulses);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL pu_core_before_periph got=%0d exp=0", viol);
        end
    endtask

    task automatic test_loss_in_run();
        int pl = -1, cl = -1, rl = -1, pe = -1, pulses = 0;
        int rp = -1, rc = -1;
        logic [7:0] exp_cnt;
        exp_cnt = CNT_EN ? 8'h01 : 8'h00;
        for (int e = 0; e < 1100; e++) begin
            @(posedge clk);
            #1;
            if (periph === 1'b0 && pl < 0) pl = e;
            if (core === 1'b0 && cl < 0) cl = e;
            if (ready === 1'b0 && rl < 0) rl = e;
            if (lost === 1'b1) begin
                pulses++;
                if (pe < 0) pe = e;
            end
            if (pl >= 0 && periph === 1'b1 && rp < 0) rp = e;
            if (cl >= 0 && core === 1'b1 && rc < 0) rc = e;
            if (e == 0) lock_i = 1'b0;
            if (e == 4) lock_i = 1'b1;
        end
        checks++;
        if (pl != 3 || cl != 3 || rl != 3) begin
            failures++;
            $display("FAIL run_loss_drop got=%0d/%0d/%0d exp=3/3/3",
                     pl, cl, rl);
        end
        checks++;
        if (pulses != 1 || pe != 3) begin
            failures++;
            $display("FAIL run_loss_pulse got=%0d@%0d exp=1@3", pulses, pe);
        end
        checks++;
        if (rp != 1031) begin
            failures++;
            $display("FAIL run_loss_periph_again got=%0d exp=1031", rp);
        end
        checks++;
        if (rc != 1047) begin
            failures++;
            $display("FAIL run_loss_core_again got=%0d exp=1047", rc);
        end
        checks++;
        if (loss_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL run_loss_cnt got=%h exp=%h", loss_cnt, exp_cnt);
        end
    endtask

    task automatic test_early_drop();
        int fp = -1, fc = -1, pulses = 0;
        restart();
        for (int e = 0; e < 1560; e++) begin
            @(posedge clk);
            #1;
            if (periph === 1'b1 && fp < 0) fp = e;
            if (core === 1'b1 && fc < 0) fc = e;
            if (lost !== 1'b0) pulses++;
            if (e == 502) lock_i = 1'b0;
            if (e == 505) lock_i = 1'b1;
        end
        checks++;
        if (fp != 1532) begin
            failures++;
            $display("FAIL early_periph_edge got=%0d exp=1532", fp);
        end
        checks++;
        if (fc != 1548) begin
            failures++;
            $display("FAIL early_core_edge got=%0d exp=1548", fc);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL early_lock_lost got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_loss_terminal();
        logic p1041 = 1'b0, p1042 = 1'b1;
        int core_seen = 0, ready_seen = 0, pe = -1, pulses = 0;
        logic [7:0] exp_cnt;
        exp_cnt = CNT_EN ? 8'h01 : 8'h00;
        restart();
        for (int e = 0; e < 1100; e++) begin
            @(posedge clk);
            #1;
            if (e == 1041) p1041 = periph;
            if (e == 1042) p1042 = periph;
            if (core !== 1'b0) core_seen++;
            if (ready !== 1'b0) ready_seen++;
            if (lost === 1'b1) begin
                pulses++;
                if (pe < 0) pe = e;
            end
            if (e == 1039) lock_i = 1'b0;
            if (e == 1043) lock_i = 1'b1;
        end
        checks++;
        if (p1041 !== 1'b1 || p1042 !== 1'b0) begin
            failures++;
            $display("FAIL term_periph got=%b%b exp=10", p1041, p1042);
        end
        checks++;
        if (core_seen != 0 || ready_seen != 0) begin
            failures++;
            $display("FAIL term_core_released got=%0d/%0d exp=0/0",
                     core_seen, ready_seen);
        end
        checks++;
        if (pulses != 1 || pe != 1042) begin
            failures++;
            $display("FAIL term_pulse got=%0d@%0d exp=1@1042", pulses, pe);
        end
        checks++;
        if (loss_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL term_loss_cnt got=%h exp=%h", loss_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (1045) @(posedge clk);
        #1;
        checks++;
        if ({periph, core, ready} !== 3'b111) begin
            failures++;
            $display("FAIL async_pre_run got=%b exp=111",
                     {periph, core, ready});
        end
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({periph, core, ready, lost} !== 4'b0000) begin
            failures++;
            $display("FAIL async_outputs got=%b exp=0000",
                     {periph, core, ready, lost});
        end
        checks++;
        if (loss_cnt !== 8'h00) begin
            failures++;
            $display("FAIL async_loss_cnt got=%h exp=00", loss_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_loss_count();
        int timeouts = 0, pulses = 0, k;
        logic [7:0] c10 = 8'h55, c255 = 8'h55;
        logic [7:0] e10, eff;
        e10 = CNT_EN ? 8'd10 : 8'h00;
        eff = CNT_EN ? 8'hFF : 8'h00;
        for (int n = 0; n < 300; n++) begin
            lock2 = 1'b1;
            k = 0;
            while (ready2 !== 1'b1 && k < 50) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (ready2 !== 1'b1) timeouts++;
            if (n == 10) c10 = loss_cnt2;
            if (n == 255) c255 = loss_cnt2;
            lock2 = 1'b0;
            k = 0;
            while (lost2 !== 1'b1 && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (lost2 === 1'b1) pulses++;
            else timeouts++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (timeouts != 0 || pulses != 300) begin
            failures++;
            $display("FAIL cnt_events got=%0d pulses %0d timeouts exp=300/0",
                     pulses, timeouts);
        end
        checks++;
        if (c10 !== e10) begin
            failures++;
            $display("FAIL cnt_after_10 got=%h exp=%h", c10, e10);
        end
        checks++;
        if (c255 !== eff) begin
            failures++;
            $display("FAIL cnt_after_255 got=%h exp=%h", c255, eff);
        end
        checks++;
        if (loss_cnt2 !== eff) begin
            failures++;
            $display("FAIL cnt_saturated got=%h exp=%h", loss_cnt2, eff);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_loss_in_run();
        test_early_drop();
        test_loss_terminal();
        test_async_reset();
        test_loss_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
- Consumes the clock-conditioning block's LOCK output and generates staged, glitch-safe reset releases for the SoC.
- The peripheral reset is released first. The core reset is released after a further delay.
- Runs on the free-running RC oscillator clock, the same source that feeds the CCC. It therefore keeps operating while the PLL is unlocked.
- Sits between the FCCC instance and the RudolV core/peripheral reset inputs in the top level.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for lock_i; must be >= 2.
- SETTLE_CYCLES, 1024: consecutive synchronized-lock cycles required before peripheral release; must be >= 1.
- CORE_DELAY, 16: cycles between peripheral release and core release; must be >= 1.

Ports:
- clk  in  1  free-running RC oscillator clock (25/50 MHz).
- rstn  in  1  asynchronous active-low reset; deassertion is synchronous to clk (upstream guarantees this).
- lock_i  in  1  PLL LOCK, asynchronous to clk.
- rstn_periph_o  out  1  active-low peripheral reset, registered.
- rstn_core_o  out  1  active-low core reset, registered.
- ready_o  out  1  high in RUN state.
- lock_lost_o  out  1  one-cycle pulse when lock drops after SETTLE was reached.
- loss_cnt_o  out  8  lock-loss event count; see Optional Feature.

Behaviour:
- Reset (rstn=0, asynchronous): state=RST; rstn_periph_o=0, rstn_core_o=0, ready_o=0, lock_lost_o=0, loss_cnt_o=0, counter=0, synchronizer flops=0.
- lock_i passes through a SYNC_STAGES flop chain; its output is lock_s. Nothing else samples lock_i.
- Counter width is clog2(max(SETTLE_CYCLES, CORE_DELAY)+1). The counter never wraps.
- FSM states: RST, WAIT_LOCK, SETTLE, REL_PERIPH, RUN.
  - RST -> WAIT_LOCK unconditionally on the first edge after rstn deasserts.
  - WAIT_LOCK: counter=0. lock_s=1 -> SETTLE.
  - SETTLE: counter increments each cycle. lock_s=0 -> WAIT_LOCK with counter cleared and no lock_lost_o pulse (lock never qualified). counter==SETTLE_CYCLES-1 with lock_s=1 -> REL_PERIPH, counter cleared, rstn_periph_o=1 from that edge.
  - REL_PERIPH: counter increments. counter==CORE_DELAY-1 -> RUN, rstn_core_o=1, ready_o=1.
  - RUN: holds while lock_s=1.
- Lock loss in REL_PERIPH or RUN (lock_s=0):
  - On the next edge: both resets go to 0, ready_o=0, counter=0, state=WAIT_LOCK.
  - lock_lost_o=1 for exactly that one cycle.
  - Lock loss takes priority over a simultaneous counter terminal count.
- Latency with defaults: lock_i rises and stays high before edge 0 -> lock_s=1 after edge 1 -> SETTLE entered at edge 2 -> rstn_periph_o=1 at edge 2+1024=1026 -> rstn_core_o=1 and ready_o=1 at edge 1042.
- Glitch handling: a lock_i low pulse shorter than one clk period may or may not be seen. If seen, it is treated as a full loss.
- Output invariants: the outputs never glitch. rstn_core_o=1 implies rstn_periph_o=1.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN.
- Defined: loss_cnt_o is an 8-bit counter incremented on every lock_lost_o pulse. It saturates at 8'hFF and is cleared only by rstn.
- Undefined: loss_cnt_o is tied to 8'h00 and no counter flops are synthesized. The port list is identical in both builds.

Decomposition:
- Package pll_lock_reset_pkg holds:
  - the state typedef (3-bit enum RST=0, WAIT_LOCK=1, SETTLE=2, REL_PERIPH=3, RUN=4);
  - the LOSS_CNT_W=8 constant.
- Sub-module sync_ff: a parameterised-depth bit synchronizer with async active-low reset. It is used for lock_i and is reusable for other CDC single bits.

Test Plan:
- Power-up: rstn low 5 cycles, lock_i=1 from start -> rstn_periph_o rises at edge 1026 after rstn release, rstn_core_o/ready_o at 1042, lock_lost_o never pulses.
- Early drop: lock_i low at cycle 500 of SETTLE for 3 cycles -> state returns to WAIT_LOCK, no lock_lost_o, periph release 1024 cycles after lock_s re-asserts.
- Loss in RUN: lock_i low 4 cycles -> rstn_core_o and rstn_periph_o both 0 at the same edge, one-cycle lock_lost_o, full resequence afterwards.
- Loss during REL_PERIPH on the terminal count edge -> core never released, state WAIT_LOCK, lock_lost_o pulse.
- Async reset mid-RUN: rstn low between clock edges -> all outputs 0 immediately without a clock edge; loss_cnt_o=0.
- With PLL_LOCK_LOSS_CNT_EN: 300 loss events from RUN -> loss_cnt_o=8'hFF. Without the macro, the same stimulus -> loss_cnt_o=8'h00.
